// File: rtl/sha256_msg_padder_if.sv
// Byte-in / padded-block-out handshake bundle for the SHA-256 message padder.
interface sha256_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into FIPS 180-4 padded 512-bit blocks; the block buffer
// doubles as the output register so a presented block costs no extra storage.
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  sha256_msg_padder_if.slave bus
);
  typedef enum logic {FILL, OUT} state_e;

  state_e           state_q, state_d;
  logic [511:0]     buf_q, buf_d;
  logic [5:0]       idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             pend_q, pend_d;
  logic             x80_q, x80_d;
  logic             bfirst_q, bfirst_d;
  logic             blast_q, blast_d;

  logic [LEN_W-1:0] cnt_inc;
  logic [63:0]      bitlen_in, bitlen_cur;
  logic [5:0]       nxt_idx;
  logic [8:0]       wr_lsb, pad_lsb;
  logic             in_fire;

  assign cnt_inc    = cnt_q + 1'b1;
  assign bitlen_in  = 64'(cnt_inc) << 3;
  assign bitlen_cur = 64'(cnt_q) << 3;
  assign nxt_idx    = idx_q + 6'd1;
  // Slot k lives at bits [511-8k -: 8]; for a 6-bit k, 63-k is just ~k.
  assign wr_lsb     = {~idx_q, 3'b000};
  assign pad_lsb    = {~nxt_idx, 3'b000};
  assign in_fire    = bus.in_valid && (state_q == FILL);

  assign bus.in_ready  = (state_q == FILL) && reset;
  assign bus.blk_valid = (state_q == OUT);
  assign bus.blk_data  = buf_q;
  assign bus.blk_first = bfirst_q;
  assign bus.blk_last  = blast_q;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    pend_d   = pend_q;
    x80_d    = x80_q;
    bfirst_d = bfirst_q;
    blast_d  = blast_q;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          buf_d[wr_lsb +: 8] = bus.in_data;
          idx_d = nxt_idx;
          cnt_d = cnt_inc;
          if (bus.in_last) begin
            state_d  = OUT;
            bfirst_d = first_q;
            if (idx_q != 6'd63) buf_d[pad_lsb +: 8] = 8'h80;
            if (idx_q <= 6'd54) begin
              buf_d[63:0] = bitlen_in;
              blast_d     = 1'b1;
            end else begin
              // Length field does not fit: it goes into a trailing extra block.
              blast_d = 1'b0;
              pend_d  = 1'b1;
              x80_d   = (idx_q == 6'd63);
            end
          end else if (idx_q == 6'd63) begin
            state_d  = OUT;
            bfirst_d = first_q;
            blast_d  = 1'b0;
          end
        end
      end
      OUT: begin
        if (bus.blk_ready) begin
          first_d = 1'b0;
          if (pend_q) begin
            buf_d    = {(x80_q ? 8'h80 : 8'h00), 440'd0, bitlen_cur};
            blast_d  = 1'b1;
            bfirst_d = 1'b0;
            pend_d   = 1'b0;
            x80_d    = 1'b0;
          end else begin
            state_d = FILL;
            idx_d   = '0;
            buf_d   = '0;
            if (blast_q) begin
              cnt_d   = '0;
              first_d = 1'b1;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= FILL;
      buf_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b1;
      pend_q   <= 1'b0;
      x80_q    <= 1'b0;
      bfirst_q <= 1'b0;
      blast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      pend_q   <= pend_d;
      x80_q    <= x80_d;
      bfirst_q <= bfirst_d;
      blast_q  <= blast_d;
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed boundary messages plus random traffic,
// scored against a whole-message padding model.
module tb_sha256_msg_padder;
  logic clock;
  logic reset;
  sha256_msg_padder_if bus ();

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  int           compared   = 0;
  int           mismatched = 0;
  logic [511:0] last_data;
  int           last_vcyc;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pad the whole message as a byte list, then cut it into 64-byte blocks.
  function automatic void build(input logic [7:0] msg[$], output blk_t q[$]);
    logic [7:0]  p[$];
    logic [63:0] bl;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    q = {};
    for (int b = 0; b < nb; b++) begin
      blk_t t;
      t.data = '0;
      for (int k = 0; k < 64; k++) t.data[511-8*k -: 8] = p[64*b+k];
      t.first = (b == 0);
      t.last  = (b == nb - 1);
      q.push_back(t);
    end
  endfunction

  task automatic run_msg(input logic [7:0] msg[$], input int vp, input int rp, input int hold);
    blk_t         exp[$];
    blk_t         cur;
    int           sent = 0;
    int           cyc  = 0;
    int           held = 0;
    int           vcyc = 0;
    bit           lf = 0, ph = 0, vstick = 0;
    logic [511:0] pd = '0;
    logic         pf = 1'b0, pl = 1'b0;
    build(msg, exp);
    while (exp.size() > 0 && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      bus.in_valid  = (sent < msg.size()) && (vstick || ($urandom_range(99) < vp));
      vstick        = bus.in_valid;
      bus.in_data   = (sent < msg.size()) ? msg[sent] : 8'h00;
      bus.in_last   = (sent == msg.size() - 1);
      bus.blk_ready = ($urandom_range(99) < rp);
      #1;
      if (bus.blk_valid) vcyc++;
      if (bus.blk_valid && held < hold) begin
        bus.blk_ready = 1'b0;
        held++;
      end
      chkv("rdy_vs_vld", 64'(bus.in_ready), 64'(!bus.blk_valid));
      if (lf) begin
        chkv("latency", 64'(bus.blk_valid), 64'd1);
        lf = 0;
      end
      if (ph) begin
        chk("hold_data", bus.blk_data, pd);
        chkv("hold_first", 64'(bus.blk_first), 64'(pf));
        chkv("hold_last", 64'(bus.blk_last), 64'(pl));
      end
      ph = bus.blk_valid && !bus.blk_ready;
      pd = bus.blk_data;
      pf = bus.blk_first;
      pl = bus.blk_last;
      if (bus.blk_valid && bus.blk_ready) begin
        cur = exp.pop_front();
        chk("blk_data", bus.blk_data, cur.data);
        chkv("blk_first", 64'(bus.blk_first), 64'(cur.first));
        chkv("blk_last", 64'(bus.blk_last), 64'(cur.last));
        last_data = bus.blk_data;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_last) lf = 1;
        sent++;
        vstick = 0;
      end
    end
    if (exp.size() > 0) chkv("timeout_blocks_left", 64'(exp.size()), 64'd0);
    last_vcyc = vcyc;
  endtask

  initial begin
    logic [7:0]   abc[$];
    logic [7:0]   m[$];
    logic [511:0] e;
    int           lens[12];

    abc = '{8'h61, 8'h62, 8'h63};
    lens = '{1, 54, 55, 56, 62, 63, 64, 65, 119, 120, 127, 128};
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.blk_ready = 1'b0;
    repeat (2) @(negedge clock);
    chkv("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chkv("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    chk("rst_blk_data", bus.blk_data, '0);
    chkv("rst_blk_first", 64'(bus.blk_first), 64'd0);
    chkv("rst_blk_last", 64'(bus.blk_last), 64'd0);
    reset = 1'b1;
    #1;
    chkv("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // "abc"
    run_msg(abc, 100, 100, 0);
    e = '0; e[511:480] = 32'h61626380; e[63:0] = 64'h18;
    chk("abc_const", last_data, e);

    // 55 bytes: length fits in the same block
    m = {}; for (int i = 0; i < 55; i++) m.push_back(8'h61);
    run_msg(m, 100, 100, 0);
    chkv("len55_field", last_data[63:0], 64'h1B8);
    chkv("len55_pad", 64'(last_data[71:64]), 64'h80);

    // 56 bytes: padding spills into an extra block
    m = {}; for (int i = 0; i < 56; i++) m.push_back(8'h61);
    run_msg(m, 100, 100, 0);
    e = '0; e[63:0] = 64'h1C0;
    chk("len56_extra", last_data, e);

    // 64 bytes then "abc" back-to-back
    m = {}; for (int i = 0; i < 64; i++) m.push_back(8'(i));
    run_msg(m, 100, 100, 0);
    e = '0; e[511:504] = 8'h80; e[63:0] = 64'h200;
    chk("len64_extra", last_data, e);
    run_msg(abc, 100, 100, 0);

    // Backpressure: 5 stalled cycles, handshake on the 6th
    run_msg(abc, 100, 100, 5);
    chkv("bp_valid_cycles", 64'(last_vcyc), 64'd6);

    // Reset after 20 of 70 bytes
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_data = 8'h61; bus.in_last = 1'b0; bus.blk_ready = 1'b1;
    repeat (20) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chkv("mid_rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    chkv("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chkv("mid_rel_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rel_blk_data", bus.blk_data, '0);
    run_msg(abc, 100, 100, 0);
    e = '0; e[511:480] = 32'h61626380; e[63:0] = 64'h18;
    chk("post_rst_abc", last_data, e);

    // Random traffic around the padding boundaries
    for (int t = 0; t < 12; t++) begin
      m = {};
      for (int i = 0; i < lens[t]; i++) m.push_back(8'($urandom));
      run_msg(m, $urandom_range(40, 100), $urandom_range(30, 100), 0);
    end
    for (int t = 0; t < 4; t++) begin
      m = {};
      for (int i = 0, n = $urandom_range(1, 250); i < n; i++) m.push_back(8'($urandom));
      run_msg(m, $urandom_range(40, 100), $urandom_range(30, 100), 0);
    end

    @(negedge clock);
    bus.in_valid = 1'b0; bus.blk_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
